// File: rtl/counter_ctrl_if.sv
// Requester-side command handshake for counter_ctrl: two valid/ready channels
// carrying an op code and a WIDTH-bit argument.
interface counter_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             req0_valid;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_arg;
    logic             req0_ready;

    logic             req1_valid;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_arg;
    logic             req1_ready;

    modport master (
        output req0_valid, req0_op, req0_arg,
        output req1_valid, req1_op, req1_arg,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_arg,
        input  req1_valid, req1_op, req1_arg,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/counter_ctrl.sv
// Two-requester command scheduler driving a saturating up/down counter.
// Optional macro CNT_CTRL_PRIO_EN: fixed priority (req0 wins) instead of round-robin.
module counter_ctrl #(
    parameter int WIDTH  = 5,
    parameter int STEP_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    counter_ctrl_if.slave    req,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic             done_sat,
    output logic [WIDTH-1:0] cnt_IN,
    output logic             cnt_Load,
    output logic             cnt_Up,
    output logic             cnt_Down,
    input  logic             cnt_High,
    input  logic             cnt_Low
);
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

    state_t            state, state_nx;
    logic [STEP_W-1:0] rem, rem_nx;
    logic [1:0]        op, op_nx;
    logic [WIDTH-1:0]  arg, arg_nx;
    logic              owner, owner_nx;
    logic              last_grant, last_nx;
    logic              sat_nx;
    logic              gnt0, gnt1, pref0;
    logic [1:0]        sel_op;
    logic [WIDTH-1:0]  sel_arg;
    logic              dir_up;

    // A step is blocked when the counter already sits at the limit in the travel direction.
    function automatic logic step_blocked(input logic up, input logic high, input logic low);
        return up ? high : low;
    endfunction

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        op_nx    = op;
        arg_nx   = arg;
        owner_nx = owner;
        last_nx  = last_grant;
        sat_nx   = 1'b0;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        sel_op   = req.req0_op;
        sel_arg  = req.req0_arg;
        dir_up   = (op == OP_UP);
        cnt_Load = 1'b0;
        cnt_Up   = 1'b0;
        cnt_Down = 1'b0;
        cnt_IN   = '0;
`ifdef CNT_CTRL_PRIO_EN
        pref0    = 1'b1;
`else
        pref0    = last_grant;
`endif

        case (state)
            IDLE: begin
                gnt0 = req.req0_valid & (~req.req1_valid | pref0);
                gnt1 = req.req1_valid & ~gnt0;
                if (gnt0 | gnt1) begin
                    sel_op   = gnt1 ? req.req1_op  : req.req0_op;
                    sel_arg  = gnt1 ? req.req1_arg : req.req0_arg;
                    op_nx    = sel_op;
                    owner_nx = gnt1;
                    last_nx  = gnt1;
                    arg_nx   = (sel_op == OP_CLEAR) ? '0 : sel_arg;
                    rem_nx   = '0;
                    if (sel_op == OP_LOAD || sel_op == OP_CLEAR) begin
                        state_nx = LOAD;
                    end else if (sel_arg != '0) begin
                        state_nx = COUNT;
                        rem_nx   = STEP_W'(sel_arg);
                    end else begin
                        state_nx = DONE;
                    end
                end
            end
            LOAD: begin
                cnt_Load = 1'b1;
                cnt_IN   = arg;
                state_nx = DONE;
            end
            COUNT: begin
                if (rem != '0 && !step_blocked(dir_up, cnt_High, cnt_Low)) begin
                    cnt_Up   = dir_up;
                    cnt_Down = ~dir_up;
                    rem_nx   = rem - STEP_W'(1);
                    if (rem == STEP_W'(1)) state_nx = DONE;
                end else begin
                    // Saturated with steps still owed: report it and drop the remainder.
                    sat_nx   = (rem != '0);
                    rem_nx   = '0;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign req.req0_ready = gnt0;
    assign req.req1_ready = gnt1;
    assign busy           = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            rem        <= '0;
            op         <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            done       <= 1'b0;
            done_id    <= 1'b0;
            done_sat   <= 1'b0;
        end else begin
            state      <= state_nx;
            rem        <= rem_nx;
            op         <= op_nx;
            owner      <= owner_nx;
            last_grant <= last_nx;
            done       <= (state_nx == DONE);
            done_id    <= (state_nx == DONE) & owner_nx;
            done_sat   <= (state_nx == DONE) & sat_nx;
        end
    end

    always_ff @(posedge CLK) begin
        arg <= arg_nx;
    end
endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Command scheduler for the 5-bit saturating up/down counter (ports IN, Load, Up, Down, High, Low, counter).
- Two requesters issue LOAD/UP/DOWN/CLEAR commands over valid/ready. The block arbitrates between them, drives the counter's control pins one step per clock, and reports completion and saturation.
- Sits directly in front of the counter instance; it is the only agent that drives the counter.

Parameters:
- WIDTH, 5, counter data width; also the width of the command argument.
- STEP_W, 5, width of the remaining-steps register; must be at least WIDTH.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 command valid.
- req0_op  in  2  command: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
- req0_arg  in  WIDTH  LOAD value, or step count for UP/DOWN; ignored for CLEAR.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req1_valid / req1_op / req1_arg / req1_ready  same as requester 0.
- busy  out  1  a command is in progress (state not IDLE).
- done  out  1  one-cycle pulse when a command completes.
- done_id  out  1  requester that owned the completed command.
- done_sat  out  1  with done: UP/DOWN stopped early on High/Low.
- cnt_IN  out  WIDTH  drives counter IN.
- cnt_Load / cnt_Up / cnt_Down  out  1  drive counter Load/Up/Down.
- cnt_High / cnt_Low  in  1  counter saturation flags (counter==31, counter==0).

Behaviour:
- Reset:
  - RST=0 at a rising CLK edge forces IDLE, clears rem/op/owner, and sets last_grant=1 so req0 wins first.
  - Registered outputs reset to 0 (done, done_id, done_sat).
  - Combinational outputs are 0 while in IDLE with no valid request.
  - Reset mid-command abandons the command; no done pulse is produced.
- FSM states: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If any reqN_valid, grant one requester: round-robin, preferring the one not equal to last_grant; a lone requester is always granted.
  - reqN_ready=1 (combinational) for the granted requester only; the other ready stays 0.
  - On valid&ready: latch op/arg/owner and update last_grant.
  - Transition: LOAD/CLEAR -> LOAD; UP/DOWN with arg!=0 -> COUNT (rem=arg); UP/DOWN with arg==0 -> DONE (sat=0).
- LOAD:
  - cnt_Load=1, cnt_IN = arg (0 for CLEAR), for exactly one cycle.
  - Next state DONE; the counter shows the new value on the following cycle.
- COUNT:
  - cnt_Up  = dir_up & ~cnt_High & (rem!=0).
  - cnt_Down = ~dir_up & ~cnt_Low & (rem!=0).
  - Each cycle a step pin is asserted, rem decrements by 1.
  - Leave to DONE when rem reaches 0 after a step (sat=0), or when the relevant flag blocks a step while rem!=0 (sat=1, rem discarded).
- DONE: done=1, done_id=owner, done_sat=sat for one cycle, then IDLE. No new request is accepted in DONE.
- Pin exclusivity:
  - cnt_Load, cnt_Up and cnt_Down are mutually exclusive and never asserted together.
  - cnt_IN=0 outside LOAD.
- Throughput and latency:
  - LOAD: 3 cycles accept-to-done (IDLE, LOAD, DONE).
  - UP/DOWN of N unblocked steps: N+2 cycles.
- Requester rules:
  - Requests must hold valid/op/arg stable until ready.
  - Changing op while valid and not ready is undefined and not checked.

Optional Feature:
- Macro CNT_CTRL_PRIO_EN.
- Defined: fixed priority, req0 always wins when both are valid; last_grant is unused.
- Undefined: round-robin as above.
- All other behaviour is identical.

Test Plan:
- Reset then req0 LOAD arg=5 -> req0_ready=1 in the accept cycle; cnt_Load=1 with cnt_IN=5 for 1 cycle; done=1 with done_id=0, done_sat=0 two cycles after accept; counter=5.
- Counter at 5, req1 UP arg=3 -> cnt_Up high exactly 3 cycles; counter=8; done_id=1, done_sat=0.
- Counter at 29, req0 UP arg=10 -> 2 Up pulses, counter=31, done_sat=1; cnt_Up never asserted while High=1.
- Counter at 2, DOWN arg=7 -> counter=0, done_sat=1. Then DOWN arg=0 -> done next cycle, no Down pulse, done_sat=0.
- req0 and req1 both valid continuously with UP arg=1 -> grants alternate 0,1,0,1. With CNT_CTRL_PRIO_EN, req0 is granted every time.
- RST=0 asserted mid-COUNT (rem=4) -> next cycle IDLE, busy=0, no done pulse, no step pins asserted; the next simultaneous request grants req0.
